snake_body_engine: RTL and testbench

Parametrised, fully sequential snake-body store and pixel-hit engine for the VGA snake display. It keeps every body segment of up to `NUM_SNAKES` snakes in registers. It applies per-snake move/grow steps with board wrap-around and detects self and cross collisions. It answers pipelined "which snake occupies board cell X" queries from the pixel path. It replaces per-pixel recomputation of body positions from head + direction chains, and supports a variable board size, snake count and maximum length.

---
 rtl/snake_pkg.sv | 16 +
 rtl/snake_seg_store.sv | 140 ++++++++++++++
 rtl/snake_body_engine.sv | 117 +++++++++++
 tb/tb_snake_body_engine.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared direction encoding and default board/snake dimensions for the snake display.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    localparam int unsigned DEF_NUM_SNAKES = 2;
    localparam int unsigned DEF_MAX_LEN    = 50;
    localparam int unsigned DEF_BOARD_W    = 40;
    localparam int unsigned DEF_BOARD_H    = 40;

endpackage

// File: rtl/snake_seg_store.sv
// One snake: segment shift register, length, sticky collide flag, wrapped head
// advance, and per-segment compares for the pixel query and for foreign heads.
module snake_seg_store
    import snake_pkg::*;
#(
    parameter int unsigned NUM_SNAKES = DEF_NUM_SNAKES,
    parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
    parameter int unsigned BOARD_W    = DEF_BOARD_W,
    parameter int unsigned BOARD_H    = DEF_BOARD_H,
    parameter int unsigned POS_W      = $clog2(BOARD_W * BOARD_H),
    parameter int unsigned LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init_valid,
    input  logic [POS_W-1:0]            init_pos,
    input  logic [LEN_W-1:0]            init_len,
    input  logic                        step_valid,
    input  logic [1:0]                  step_dir,
    input  logic                        step_grow,
    input  logic                        collide_set,
    input  logic [POS_W-1:0]            query_pos,
    input  logic [NUM_SNAKES*POS_W-1:0] cand_heads,
    output logic [POS_W-1:0]            new_head_c,
    output logic                        step_c,
    output logic                        self_hit_c,
    output logic [NUM_SNAKES-1:0]       foreign_hit_c,
    output logic                        query_hit_c,
    output logic                        query_head_c,
    output logic [POS_W-1:0]            head_pos,
    output logic [LEN_W-1:0]            length,
    output logic                        collide
);

    logic [POS_W-1:0] seg [MAX_LEN];
    logic [LEN_W-1:0] grow_len;
    logic [LEN_W-1:0] self_lim;
    logic [LEN_W-1:0] occ_lim;
    logic [LEN_W-1:0] clamp_len;
    int unsigned      hp;
    int unsigned      hcol;
    int unsigned      hn;

    assign head_pos = seg[0];

    // A step is taken only by a live, unfrozen snake that is not being re-initialised.
    assign step_c = step_valid && (length != '0) && !collide && !init_valid;

    // Candidate head for this cycle's step, wrapping at the board edges.
    always_comb begin
        hp   = 32'(seg[0]);
        hcol = hp % BOARD_W;
        hn   = hp;
        case (dir_e'(step_dir))
            DIR_UP:    hn = (hp < BOARD_W) ? hp + (BOARD_H - 1) * BOARD_W : hp - BOARD_W;
            DIR_RIGHT: hn = (hcol == BOARD_W - 1) ? hp - (BOARD_W - 1) : hp + 1;
            DIR_DOWN:  hn = (hp >= (BOARD_H - 1) * BOARD_W) ? hp - (BOARD_H - 1) * BOARD_W : hp + BOARD_W;
            DIR_LEFT:  hn = (hcol == 0) ? hp + (BOARD_W - 1) : hp - 1;
        endcase
        new_head_c = POS_W'(hn);
    end

    // Length bookkeeping: grown length, self-collision window, post-step occupancy, init clamp.
    always_comb begin
        grow_len = (length < LEN_W'(MAX_LEN)) ? length + LEN_W'(1) : length;
        self_lim = step_grow ? length : length - LEN_W'(1);
        occ_lim  = length;
        if (step_c) begin
            occ_lim = (step_grow && (length < LEN_W'(MAX_LEN))) ? length : length - LEN_W'(1);
        end
        clamp_len = init_len;
        if (init_len == '0) begin
            clamp_len = LEN_W'(1);
        end else if (init_len > LEN_W'(MAX_LEN)) begin
            clamp_len = LEN_W'(MAX_LEN);
        end
    end

    // New head against own body, excluding the current head and a vacating tail.
    always_comb begin
        self_hit_c = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < self_lim) && (seg[i] == new_head_c)) begin
                self_hit_c = 1'b1;
            end
        end
    end

    // Other snakes' new heads against this snake's occupancy after its own step.
    always_comb begin
        foreign_hit_c = '0;
        for (int k = 0; k < NUM_SNAKES; k++) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if ((LEN_W'(i) < occ_lim) && (seg[i] == cand_heads[k*POS_W +: POS_W])) begin
                    foreign_hit_c[k] = 1'b1;
                end
            end
        end
    end

    // Pixel query against the live segments.
    always_comb begin
        query_hit_c  = 1'b0;
        query_head_c = (length != '0) && (seg[0] == query_pos);
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < length) && (seg[i] == query_pos)) begin
                query_hit_c = 1'b1;
            end
        end
    end

    // Segment, length and collide state: init wins over step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg[i] <= '0;
            end
            length  <= '0;
            collide <= 1'b0;
        end else if (init_valid) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg[i] <= init_pos;
            end
            length  <= clamp_len;
            collide <= 1'b0;
        end else if (step_c) begin
            seg[0] <= new_head_c;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg[i] <= seg[i-1];
            end
            if (step_grow) begin
                length <= grow_len;
            end
            if (collide_set) begin
                collide <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_body_engine.sv
// Multi-snake body store: per-snake segment stores, cross-snake collision
// combining, and the two-stage pixel query pipeline.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int unsigned NUM_SNAKES = DEF_NUM_SNAKES,
    parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
    parameter int unsigned BOARD_W    = DEF_BOARD_W,
    parameter int unsigned BOARD_H    = DEF_BOARD_H,
    parameter int unsigned POS_W      = $clog2(BOARD_W * BOARD_H),
    parameter int unsigned LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                        iVGA_CLK,
    input  logic                        reset,
    input  logic [NUM_SNAKES-1:0]       init_valid,
    input  logic [NUM_SNAKES*POS_W-1:0] init_pos,
    input  logic [NUM_SNAKES*LEN_W-1:0] init_len,
    input  logic [NUM_SNAKES-1:0]       step_valid,
    input  logic [NUM_SNAKES*2-1:0]     step_dir,
    input  logic [NUM_SNAKES-1:0]       step_grow,
    input  logic                        query_valid,
    input  logic [POS_W-1:0]            query_pos,
    output logic                        hit_valid,
    output logic [NUM_SNAKES-1:0]       hit_mask,
    output logic [NUM_SNAKES-1:0]       head_mask,
    output logic [NUM_SNAKES*POS_W-1:0] head_pos,
    output logic [NUM_SNAKES*LEN_W-1:0] length,
    output logic [NUM_SNAKES-1:0]       collide
);

    logic [POS_W-1:0]            new_head [NUM_SNAKES];
    logic [NUM_SNAKES-1:0]       foreign_hit [NUM_SNAKES];  // [m][n]: n's new head lands on m
    logic [NUM_SNAKES-1:0]       step_eff;
    logic [NUM_SNAKES-1:0]       self_hit;
    logic [NUM_SNAKES-1:0]       collide_set;
    logic [NUM_SNAKES-1:0]       q_hit;
    logic [NUM_SNAKES-1:0]       q_head;
    logic [NUM_SNAKES*POS_W-1:0] cand_heads;
    logic                        q_valid_r;
    logic [POS_W-1:0]            q_pos_r;

    for (genvar g = 0; g < NUM_SNAKES; g++) begin : g_snake
        snake_seg_store #(
            .NUM_SNAKES(NUM_SNAKES),
            .MAX_LEN   (MAX_LEN),
            .BOARD_W   (BOARD_W),
            .BOARD_H   (BOARD_H),
            .POS_W     (POS_W),
            .LEN_W     (LEN_W)
        ) u_store (
            .clk          (iVGA_CLK),
            .rst          (reset),
            .init_valid   (init_valid[g]),
            .init_pos     (init_pos[g*POS_W +: POS_W]),
            .init_len     (init_len[g*LEN_W +: LEN_W]),
            .step_valid   (step_valid[g]),
            .step_dir     (step_dir[g*2 +: 2]),
            .step_grow    (step_grow[g]),
            .collide_set  (collide_set[g]),
            .query_pos    (q_pos_r),
            .cand_heads   (cand_heads),
            .new_head_c   (new_head[g]),
            .step_c       (step_eff[g]),
            .self_hit_c   (self_hit[g]),
            .foreign_hit_c(foreign_hit[g]),
            .query_hit_c  (q_hit[g]),
            .query_head_c (q_head[g]),
            .head_pos     (head_pos[g*POS_W +: POS_W]),
            .length       (length[g*LEN_W +: LEN_W]),
            .collide      (collide[g])
        );
    end

    // Broadcast every candidate head to all stores for cross-occupancy compares.
    always_comb begin
        cand_heads = '0;
        for (int n = 0; n < NUM_SNAKES; n++) begin
            cand_heads[n*POS_W +: POS_W] = new_head[n];
        end
    end

    // Per-snake collision: self body, other bodies after their step, or a shared new head.
    always_comb begin
        collide_set = '0;
        for (int n = 0; n < NUM_SNAKES; n++) begin
            collide_set[n] = self_hit[n];
            for (int m = 0; m < NUM_SNAKES; m++) begin
                if (m != n) begin
                    if (foreign_hit[m][n]) begin
                        collide_set[n] = 1'b1;
                    end
                    if (step_eff[m] && (new_head[m] == new_head[n])) begin
                        collide_set[n] = 1'b1;
                    end
                end
            end
        end
    end

    // Query pipeline: register the cell, then register masks compared against updated state.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            q_valid_r <= 1'b0;
            q_pos_r   <= '0;
            hit_valid <= 1'b0;
            hit_mask  <= '0;
            head_mask <= '0;
        end else begin
            q_valid_r <= query_valid;
            q_pos_r   <= query_pos;
            hit_valid <= q_valid_r;
            hit_mask  <= q_valid_r ? q_hit  : '0;
            head_mask <= q_valid_r ? q_head : '0;
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine: directed tables/sequences plus a
// randomized run against a queue-based behavioural model.
module tb_snake_body_engine;

    localparam int NS = 2;
    localparam int ML = 50;
    localparam int BW = 40;
    localparam int BH = 40;
    localparam int PW = 11;
    localparam int LW = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    init_valid;
    logic [NS*PW-1:0] init_pos;
    logic [NS*LW-1:0] init_len;
    logic [NS-1:0]    step_valid;
    logic [NS*2-1:0]  step_dir;
    logic [NS-1:0]    step_grow;
    logic             query_valid;
    logic [PW-1:0]    query_pos;
    logic             hit_valid;
    logic [NS-1:0]    hit_mask;
    logic [NS-1:0]    head_mask;
    logic [NS*PW-1:0] head_pos;
    logic [NS*LW-1:0] length;
    logic [NS-1:0]    collide;

    always #5 clk = ~clk;

    snake_body_engine dut (
        .iVGA_CLK   (clk),
        .reset      (rst),
        .init_valid (init_valid),
        .init_pos   (init_pos),
        .init_len   (init_len),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .step_grow  (step_grow),
        .query_valid(query_valid),
        .query_pos  (query_pos),
        .hit_valid  (hit_valid),
        .hit_mask   (hit_mask),
        .head_mask  (head_mask),
        .head_pos   (head_pos),
        .length     (length),
        .collide    (collide)
    );

    // Behavioural model: each body is a queue of cells, head at index 0.
    int          body [NS][$];
    int          mlen [NS];
    bit          mcol [NS];
    bit          pend_v;
    logic [NS-1:0] pend_hit;
    logic [NS-1:0] pend_head;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int dir;
        int exp_head;
    } wrap_vec_t;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int get_head(int n);
        return int'(head_pos[n*PW +: PW]);
    endfunction

    function automatic int get_len(int n);
        return int'(length[n*LW +: LW]);
    endfunction

    function automatic int move_cell(int p, int d);
        int r = p / BW;
        int c = p % BW;
        case (d)
            0: r = (r + BH - 1) % BH;
            1: c = (c + 1) % BW;
            2: r = (r + 1) % BH;
            default: c = (c + BW - 1) % BW;
        endcase
        return r * BW + c;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < NS; n++) begin
            body[n].delete();
            mlen[n] = 0;
            mcol[n] = 1'b0;
        end
        pend_v    = 1'b0;
        pend_hit  = '0;
        pend_head = '0;
    endfunction

    // Apply the rules for one clock edge using the inputs the DUT just sampled.
    function automatic void model_edge();
        int nh [NS];
        bit st [NS];
        bit cs [NS];
        int nlen [NS];
        int lp;
        int il;
        for (int n = 0; n < NS; n++) begin
            st[n] = step_valid[n] && (mlen[n] > 0) && !mcol[n] && !init_valid[n];
            nh[n] = 0;
            nlen[n] = mlen[n];
            if (st[n]) begin
                nh[n] = move_cell(body[n][0], int'(step_dir[2*n +: 2]));
                if (step_grow[n] && mlen[n] < ML) nlen[n] = mlen[n] + 1;
            end
        end
        for (int n = 0; n < NS; n++) begin
            cs[n] = 1'b0;
            if (st[n]) begin
                lp = step_grow[n] ? mlen[n] : mlen[n] - 1;
                for (int i = 1; i < lp; i++) if (body[n][i] == nh[n]) cs[n] = 1'b1;
                for (int m = 0; m < NS; m++) begin
                    if (m != n && mlen[m] > 0) begin
                        if (st[m]) begin
                            if (nh[m] == nh[n]) cs[n] = 1'b1;
                            for (int i = 0; i < nlen[m] - 1; i++) if (body[m][i] == nh[n]) cs[n] = 1'b1;
                        end else begin
                            for (int i = 0; i < mlen[m]; i++) if (body[m][i] == nh[n]) cs[n] = 1'b1;
                        end
                    end
                end
            end
        end
        for (int n = 0; n < NS; n++) begin
            if (init_valid[n]) begin
                il = int'(init_len[n*LW +: LW]);
                if (il == 0) il = 1;
                if (il > ML) il = ML;
                body[n].delete();
                for (int i = 0; i < il; i++) body[n].push_back(int'(init_pos[n*PW +: PW]));
                mlen[n] = il;
                mcol[n] = 1'b0;
            end else if (st[n]) begin
                body[n].push_front(nh[n]);
                if (body[n].size() > nlen[n]) void'(body[n].pop_back());
                mlen[n] = nlen[n];
                if (cs[n]) mcol[n] = 1'b1;
            end
        end
    endfunction

    function automatic void check_outputs();
        check("hit_valid", int'(hit_valid), int'(pend_v));
        check("hit_mask", int'(hit_mask), pend_v ? int'(pend_hit) : 0);
        check("head_mask", int'(head_mask), pend_v ? int'(pend_head) : 0);
        for (int n = 0; n < NS; n++) begin
            check("model head_pos", get_head(n), (mlen[n] > 0) ? body[n][0] : 0);
            check("model length", get_len(n), mlen[n]);
            check("model collide", int'(collide[n]), int'(mcol[n]));
        end
    endfunction

    // Query sampled at this edge is answered from the state this edge produced.
    function automatic void capture_query();
        int q = int'(query_pos);
        pend_v    = query_valid;
        pend_hit  = '0;
        pend_head = '0;
        for (int n = 0; n < NS; n++) begin
            for (int i = 0; i < mlen[n]; i++) if (body[n][i] == q) pend_hit[n] = 1'b1;
            if (mlen[n] > 0 && body[n][0] == q) pend_head[n] = 1'b1;
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        check_outputs();
        capture_query();
    endtask

    task automatic clear_inputs();
        init_valid  = '0;
        init_pos    = '0;
        init_len    = '0;
        step_valid  = '0;
        step_dir    = '0;
        step_grow   = '0;
        query_valid = 1'b0;
        query_pos   = '0;
    endtask

    task automatic set_init(int n, int pos, int len);
        init_valid[n]           = 1'b1;
        init_pos[n*PW +: PW]    = PW'(pos);
        init_len[n*LW +: LW]    = LW'(len);
    endtask

    task automatic set_step(int n, int dir, bit grow);
        step_valid[n]       = 1'b1;
        step_dir[2*n +: 2]  = 2'(dir);
        step_grow[n]        = grow;
    endtask

    task automatic do_init(int n, int pos, int len);
        clear_inputs();
        set_init(n, pos, len);
        cycle();
        clear_inputs();
    endtask

    task automatic do_step(int n, int dir, bit grow);
        clear_inputs();
        set_step(n, dir, grow);
        cycle();
        clear_inputs();
    endtask

    task automatic do_query(int pos);
        clear_inputs();
        query_valid = 1'b1;
        query_pos   = PW'(pos);
        cycle();
        query_valid = 1'b0;
        cycle();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, " hit_valid"}, int'(hit_valid), 0);
        check({tag, " hit_mask"}, int'(hit_mask), 0);
        check({tag, " head_mask"}, int'(head_mask), 0);
        check({tag, " head_pos"}, int'(head_pos), 0);
        check({tag, " length"}, int'(length), 0);
        check({tag, " collide"}, int'(collide), 0);
    endtask

    wrap_vec_t wrap_tab [4];

    initial begin
        int qp;
        int s;
        wrap_tab[0] = '{dir: 1, exp_head: 0};
        wrap_tab[1] = '{dir: 0, exp_head: 1560};
        wrap_tab[2] = '{dir: 3, exp_head: 1599};
        wrap_tab[3] = '{dir: 2, exp_head: 39};

        // Power-on reset.
        clear_inputs();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("por");
        rst = 1'b0;

        // Basic move and query.
        do_init(0, 425, 3);
        clear_inputs();
        set_step(0, 1, 1'b0);
        cycle();
        cycle();
        clear_inputs();
        check("move head", get_head(0), 427);
        check("move length", get_len(0), 3);
        do_query(426);
        check("q426 valid", int'(hit_valid), 1);
        check("q426 hit", int'(hit_mask), 1);
        check("q426 head", int'(head_mask), 0);
        do_query(427);
        check("q427 hit", int'(hit_mask), 1);
        check("q427 head", int'(head_mask), 1);
        do_query(425);
        check("q425 tail hit", int'(hit_mask), 1);
        do_query(424);
        check("q424 beyond tail", int'(hit_mask), 0);

        // Wrap-around table, also checks init_len 0 loads length 1.
        do_init(0, 39, 0);
        check("init len0 clamp", get_len(0), 1);
        for (int i = 0; i < 4; i++) begin
            do_step(0, wrap_tab[i].dir, 1'b0);
            check("wrap head", get_head(0), wrap_tab[i].exp_head);
        end

        // Grow to saturation on a staircase path.
        do_init(0, 0, 1);
        for (int k = 1; k <= 60; k++) begin
            do_step(0, (k % 2 == 1) ? 1 : 2, 1'b1);
        end
        check("grow length", get_len(0), 50);
        check("grow collide", int'(collide[0]), 0);
        check("grow head", get_head(0), 1230);
        do_query(165);
        check("grow step9 gone", int'(hit_mask), 0);
        do_query(205);
        check("grow step10 gone", int'(hit_mask), 0);
        do_query(206);
        check("grow step11 tail", int'(hit_mask), 1);

        // Init length above MAX_LEN clamps.
        do_init(0, 800, 63);
        check("init len clamp max", get_len(0), 50);

        // Self collision with length 5, freeze, then init clears.
        do_init(0, 500, 5);
        do_step(0, 1, 1'b0);
        do_step(0, 2, 1'b0);
        do_step(0, 3, 1'b0);
        do_step(0, 0, 1'b0);
        check("self collide", int'(collide[0]), 1);
        check("self head", get_head(0), 500);
        do_step(0, 1, 1'b0);
        check("frozen head", get_head(0), 500);
        do_init(0, 500, 4);
        check("init clears collide", int'(collide[0]), 0);
        do_step(0, 1, 1'b0);
        do_step(0, 2, 1'b0);
        do_step(0, 3, 1'b0);
        do_step(0, 0, 1'b0);
        check("tail vacates", int'(collide[0]), 0);
        check("tail vacates head", get_head(0), 500);

        // Head-on into the same cell.
        clear_inputs();
        set_init(0, 100, 1);
        set_init(1, 102, 1);
        cycle();
        clear_inputs();
        set_step(0, 1, 1'b0);
        set_step(1, 3, 1'b0);
        cycle();
        clear_inputs();
        check("headon collide", int'(collide), 3);
        check("headon head0", get_head(0), 101);
        check("headon head1", get_head(1), 101);

        // Randomized run against the model.
        for (int t = 0; t < 3000; t++) begin
            clear_inputs();
            for (int n = 0; n < NS; n++) begin
                if ($urandom_range(0, 39) == 0)
                    set_init(n, int'($urandom_range(0, BW*BH - 1)), int'($urandom_range(0, 63)));
                if ($urandom_range(0, 1) == 1)
                    set_step(n, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            end
            query_valid = ($urandom_range(0, 3) != 0);
            s = int'($urandom_range(0, NS - 1));
            if ($urandom_range(0, 1) == 1 && mlen[s] > 0)
                qp = body[s][$urandom_range(0, mlen[s] - 1)];
            else
                qp = int'($urandom_range(0, BW*BH - 1));
            query_pos = PW'(qp);
            cycle();
        end

        // Reset in the middle of traffic drops in-flight queries.
        clear_inputs();
        query_valid = 1'b1;
        query_pos   = PW'(body[0].size() > 0 ? body[0][0] : 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        rst = 1'b0;
        model_reset();
        cycle();
        check("post reset hit_valid", int'(hit_valid), 0);
        cycle();
        cycle();
        clear_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
